// File: rtl/dp_sequencer.sv
// Job sequencer for a 2:4 sparse PE: loads the partial sum, steps activation pairs
// through the two execute phases, then hands the settled psum to a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for start; remaining latched on accept
// LOAD  | PE captures psum_in (load + execute)
// EXEC0 | first half of a pair (a_select=0); execute follows act_valid
// EXEC1 | second half of a pair (a_select=1); pair consumed, remaining--
// DRAIN | PE controls idle so psum settles after the last gated edge
// DONE  | result_valid held until result_ready
module dp_sequencer #(
   parameter int psum_bw = 20,
   parameter int len_bw  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [len_bw-1:0]  job_len,
   input  logic               abort,
   input  logic               act_valid,
   output logic               act_ready,
   input  logic [psum_bw-1:0] pe_psum,
   output logic               pe_load,
   output logic               pe_execute,
   output logic               pe_a_select,
   output logic               pe_reset,
   output logic               busy,
   output logic               result_valid,
   output logic [psum_bw-1:0] result_data,
   input  logic               result_ready,
   output logic [15:0]        jobs_done
);

   typedef enum logic [2:0] {IDLE, LOAD, EXEC0, EXEC1, DRAIN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [len_bw-1:0] remaining;
   logic              exec_q;
   logic              abort_hit;

   assign abort_hit = abort && (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = (remaining == '0) ? DRAIN : EXEC0;
         EXEC0:   if (act_valid) state_nxt = EXEC1;
         EXEC1:   state_nxt = (remaining == len_bw'(1)) ? DRAIN : EXEC0;
         DRAIN:   state_nxt = DONE;
         DONE:    if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_hit) state_nxt = IDLE;
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         remaining    <= '0;
         jobs_done    <= '0;
         result_data  <= '0;
         result_valid <= 1'b0;
         act_ready    <= 1'b0;
         pe_load      <= 1'b0;
         exec_q       <= 1'b0;
         pe_a_select  <= 1'b0;
         busy         <= 1'b0;
         pe_reset     <= 1'b1;
      end else begin
         state        <= state_nxt;
         pe_load      <= (state_nxt == LOAD);
         exec_q       <= (state_nxt == LOAD) || (state_nxt == EXEC1);
         pe_a_select  <= (state_nxt == EXEC1);
         act_ready    <= (state_nxt == EXEC1);
         busy         <= (state_nxt != IDLE);
         result_valid <= (state_nxt == DONE);
         pe_reset     <= abort_hit;
         if (state == IDLE && start)
            remaining <= job_len;
         else if (state == EXEC1 && !abort_hit)
            remaining <= remaining - len_bw'(1);
         if (state == DRAIN && !abort_hit)
            result_data <= pe_psum;
         if (state == DONE && result_ready && !abort_hit)
            jobs_done <= jobs_done + 16'd1;
      end
   end

   // The EXEC0 execute strobe follows act_valid directly so a stalled pair never clocks the PE.
   assign pe_execute = exec_q || ((state == EXEC0) && act_valid);

endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL have parameter psum_bw, default 20, meaning the PE partial-sum width.
REQ-002 The block SHALL have parameter len_bw, default 4, meaning the job_len width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 The block SHALL have port job_len, input, len_bw bits: number of activation pairs in the job, latched on an accepted start.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels the current job.
REQ-008 The block SHALL have port act_valid, input, 1 bit: upstream activation pair valid.
REQ-009 The block SHALL have port act_ready, output, 1 bit: activation pair consumed this cycle.
REQ-010 The block SHALL have port pe_psum, input, psum_bw bits: PE psum_out.
REQ-011 The block SHALL have outputs pe_load, pe_execute, pe_a_select and pe_reset, each 1 bit, which drive the PE load, execute, a_select and reset inputs (pe_reset is active-high).
REQ-012 The block SHALL have outputs busy (1 bit), result_valid (1 bit) and result_data (psum_bw bits), and input result_ready (1 bit).
REQ-013 The block SHALL have output jobs_done, 16 bits: count of completed jobs.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, EXEC0, EXEC1, DRAIN and DONE as a registered FSM with Moore outputs, except where REQ-017 states otherwise.
REQ-015 IDLE behaviour:
- busy=0.
- If start=1, latch job_len into remaining and go to LOAD.
REQ-016 LOAD behaviour (one cycle):
- pe_load=1, pe_execute=1, so the PE captures psum_in.
- Next state is DRAIN if remaining==0, else EXEC0.
REQ-017 EXEC0 behaviour:
- pe_a_select=0, pe_execute=act_valid (combinational), act_ready=0.
- If act_valid=1, go to EXEC1; otherwise stall in EXEC0.
REQ-018 EXEC1 behaviour:
- pe_a_select=1, pe_execute=1, act_ready=1.
- remaining decrements by 1.
- Next state is DRAIN if remaining==1, else EXEC0.
REQ-019 Upstream SHALL hold the activation pair and act_valid stable from its EXEC0 acceptance through EXEC1; the block does not check this.
REQ-020 DRAIN SHALL last one cycle with all PE controls 0, so the psum settles after the last gated-clock edge.
REQ-021 DONE behaviour:
- result_valid=1, result_data=pe_psum (registered on DRAIN->DONE).
- Hold until result_ready=1, then go to IDLE and increment jobs_done (wraps 0xFFFF->0).
REQ-022 pe_load SHALL be 1 only in LOAD, and pe_a_select SHALL be 1 only in EXEC1.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start SHALL be ignored outside IDLE, including when start and result_ready arrive together in DONE (DONE->IDLE only).
REQ-025 abort=1 in any non-IDLE state SHALL move to IDLE next cycle, assert pe_reset for that cycle, drop result_valid and leave jobs_done unchanged; abort has priority over every other transition, and abort in IDLE has no effect.
REQ-026 job_len SHALL be unsigned; the maximum 2^len_bw-1 pairs is supported without wrap, and the job takes 2*len+3 cycles from LOAD to DONE with no stalls.

Reset
REQ-027 While reset=0 at a clock edge, the FSM SHALL enter IDLE with:
- remaining=0, jobs_done=0, result_data=0.
- result_valid=0, act_ready=0, pe_load=0, pe_execute=0, pe_a_select=0.
- busy=0, pe_reset=1.
REQ-028 Reset SHALL override abort and any in-flight job; pe_reset SHALL be 1 for every cycle reset=0, plus during the abort cycle, and 0 otherwise.

Verification (the bench instantiates the 2:4 sparse PE, bw=4, weights w0=3 at index 0, w1=2 at index 2)
REQ-029 Scenario, basic job:
- Stimulus: start, job_len=2, psum_in=5, two pairs each {act0=2 idx0, act1=1 idx2}, act_valid always 1.
- Response: result_valid rises 7 cycles after LOAD, result_data=5+2*(6+2)=21, jobs_done=1.
REQ-030 Scenario, zero-length job:
- Stimulus: job_len=0, psum_in=9.
- Response: LOAD->DRAIN->DONE, result_data=9, act_ready never asserted.
REQ-031 Scenario, upstream stall:
- Stimulus: act_valid=0 for 3 cycles in EXEC0.
- Response: pe_execute=0 and the FSM stays in EXEC0 for those cycles, then the result is identical to REQ-029.
REQ-032 Scenario, output back-pressure:
- Stimulus: result_ready=0 for 4 cycles, with start pulsed during DONE.
- Response: result_data stable, start ignored, one job counted.
REQ-033 Scenario, abort mid-EXEC1:
- Stimulus: abort during EXEC1.
- Response: next cycle IDLE, pe_reset=1 for one cycle, result_valid=0, jobs_done unchanged.
REQ-034 Scenario, reset mid-job:
- Stimulus: reset=0 during EXEC0.
- Response: all outputs take the REQ-027 values next edge; a following job with job_len=1 completes normally.
